// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: HCLK-synchronous UART receive monitor.
// Decodes frames from a serial line with configurable data width, parity and
// stop bits, flags framing/parity errors and buffers decoded characters in a
// show-ahead FIFO that is drained over a valid/ready interface.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          rx,
  input  logic                          en,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [DATA_BITS-1:0]          dout_data,
  output logic                          dout_ferr,
  output logic                          dout_perr,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  logic                 rx_meta, rx_s, rx_prev, rx_fall;
  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [3:0]           bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 perr_q, perr_next;
  logic                 ferr_q, ferr_next;
  logic                 stop_ferr;
  logic                 push;
  logic [EW-1:0]        fifo_wdata;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [EW-1:0]        head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, do_push, do_pop, drop;

  // Two-flop synchronizer for the asynchronous line plus a delayed copy for edge detect
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall    = rx_prev & ~rx_s;
  assign stop_ferr  = ferr_q | ~rx_s;
  assign fifo_wdata = {perr_q, stop_ferr, shift};

  // Frame decoder state and datapath registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      perr_q  <= perr_next;
      ferr_q  <= ferr_next;
    end
  end

  // Next-state logic: bit timing, sampling, error detection and the push strobe
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_cnt;
    shift_next = shift;
    perr_next  = perr_q;
    ferr_next  = ferr_q;
    push       = 1'b0;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next = '0;
          if (rx_fall) begin
            state_next = START;
            bit_next   = '0;
            perr_next  = 1'b0;
            ferr_next  = 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_next   = '0;
            state_next = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            shift_next = {rx_s, shift[DATA_BITS-1:1]};
            bit_next   = bit_cnt + 1'b1;
            if (bit_cnt == DATA_LAST) begin
              bit_next   = '0;
              state_next = (PARITY != 0) ? PAR : STOP;
            end
          end
        end
        PAR: begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            perr_next  = ((^shift) ^ rx_s) != (PARITY == 2);
            bit_next   = '0;
            state_next = STOP;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_next  = '0;
            ferr_next = stop_ferr;
            bit_next  = bit_cnt + 1'b1;
            if (bit_cnt == STOP_LAST) begin
              push       = 1'b1;
              bit_next   = '0;
              state_next = stop_ferr ? WAIT_HIGH : IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          cnt_next = '0;
          if (rx_s) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign full       = (level == FULL_LVL);
  assign dout_valid = (level != '0);
  assign do_pop     = dout_valid & dout_ready;
  assign do_push    = push & (~full | do_pop);
  assign drop       = push & full & ~do_pop;

  // FIFO storage; entries only need to be valid while counted in level
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= fifo_wdata;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag; an explicit clear beats a simultaneous drop
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     overflow <= 1'b0;
    else if (clr_ovf) overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
  end

  assign head      = mem[rd_ptr];
  assign dout_data = dout_valid ? head[DATA_BITS-1:0] : '0;
  assign dout_ferr = dout_valid & head[DATA_BITS];
  assign dout_perr = dout_valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed self-checking bench for uart_rx_monitor.
// Three instances cover the default configuration, even parity and a
// four-entry FIFO; all share clock, reset and enable.
module tb_uart_rx_monitor;

  localparam int CPB = 16;

  logic       HCLK;
  logic       HRESETn;
  logic       en;
  logic [2:0] rx_line;
  logic [2:0] ready;
  logic [2:0] clr;

  logic       v0, f0, p0, o0;
  logic [7:0] d0;
  logic [4:0] l0;
  logic       v1, f1, p1, o1;
  logic [7:0] d1;
  logic [4:0] l1;
  logic       v2, f2, p2, o2;
  logic [7:0] d2;
  logic [2:0] l2;

  int checks = 0;
  int errors = 0;
  logic [9:0] mon_q[$];

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_def (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx_line[0]), .en(en),
    .dout_valid(v0), .dout_ready(ready[0]), .dout_data(d0), .dout_ferr(f0), .dout_perr(p0),
    .level(l0), .overflow(o0), .clr_ovf(clr[0])
  );

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_par (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx_line[1]), .en(en),
    .dout_valid(v1), .dout_ready(ready[1]), .dout_data(d1), .dout_ferr(f1), .dout_perr(p1),
    .level(l1), .overflow(o1), .clr_ovf(clr[1])
  );

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_fifo4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx_line[2]), .en(en),
    .dout_valid(v2), .dout_ready(ready[2]), .dout_data(d2), .dout_ferr(f2), .dout_perr(p2),
    .level(l2), .overflow(o2), .clr_ovf(clr[2])
  );

  // 10 ns clock
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Record every entry popped from the default instance
  always @(negedge HCLK) begin
    if (v0 && ready[0]) mon_q.push_back({p0, f0, d0});
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic v);
    rx_line[sel] = v;
    repeat (CPB) @(negedge HCLK);
  endtask

  task automatic apply_stimulus(input int sel, input logic [7:0] data, input bit use_par, input logic par_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (use_par) drive_bit(sel, par_bit);
    drive_bit(sel, 1'b1);
  endtask

  task automatic pop_entry(input int sel);
    ready[sel] = 1'b1;
    @(negedge HCLK);
    ready[sel] = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0;
    en      = 1'b1;
    rx_line = '1;
    ready   = '0;
    clr     = '0;
    repeat (3) @(negedge HCLK);

    $display("[TB] reset state");
    check_output("rst_valid",    32'(v0), 32'd0);
    check_output("rst_data",     32'(d0), 32'd0);
    check_output("rst_ferr",     32'(f0), 32'd0);
    check_output("rst_perr",     32'(p0), 32'd0);
    check_output("rst_level",    32'(l0), 32'd0);
    check_output("rst_overflow", 32'(o0), 32'd0);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);

    $display("[TB] back-to-back 0x48 0x69 with ready high");
    ready[0] = 1'b1;
    apply_stimulus(0, 8'h48, 1'b0, 1'b0);
    apply_stimulus(0, 8'h69, 1'b0, 1'b0);
    repeat (40) @(negedge HCLK);
    ready[0] = 1'b0;
    check_output("b2b_count",    32'(mon_q.size()), 32'd2);
    check_output("b2b_first",    32'(mon_q[0]), 32'h048);
    check_output("b2b_second",   32'(mon_q[1]), 32'h069);
    check_output("b2b_level",    32'(l0), 32'd0);
    check_output("b2b_overflow", 32'(o0), 32'd0);

    $display("[TB] ready while empty");
    pop_entry(0);
    check_output("empty_pop_level", 32'(l0), 32'd0);
    check_output("empty_pop_valid", 32'(v0), 32'd0);

    $display("[TB] even parity, wrong then right parity bit");
    apply_stimulus(1, 8'h07, 1'b1, 1'b0);
    repeat (40) @(negedge HCLK);
    check_output("par_bad_level", 32'(l1), 32'd1);
    check_output("par_bad_data",  32'(d1), 32'h07);
    check_output("par_bad_perr",  32'(p1), 32'd1);
    check_output("par_bad_ferr",  32'(f1), 32'd0);
    pop_entry(1);
    check_output("par_pop_level", 32'(l1), 32'd0);
    apply_stimulus(1, 8'h07, 1'b1, 1'b1);
    repeat (40) @(negedge HCLK);
    check_output("par_ok_level", 32'(l1), 32'd1);
    check_output("par_ok_data",  32'(d1), 32'h07);
    check_output("par_ok_perr",  32'(p1), 32'd0);
    check_output("par_ok_ferr",  32'(f1), 32'd0);
    pop_entry(1);

    $display("[TB] break condition");
    rx_line[0] = 1'b0;
    repeat (20 * CPB) @(negedge HCLK);
    check_output("break_level_low", 32'(l0), 32'd1);
    rx_line[0] = 1'b1;
    repeat (3 * CPB) @(negedge HCLK);
    check_output("break_level", 32'(l0), 32'd1);
    check_output("break_data",  32'(d0), 32'h00);
    check_output("break_ferr",  32'(f0), 32'd1);
    check_output("break_perr",  32'(p0), 32'd0);
    pop_entry(0);
    check_output("break_pop_level", 32'(l0), 32'd0);

    $display("[TB] short glitch");
    rx_line[0] = 1'b0;
    repeat (CPB / 4) @(negedge HCLK);
    rx_line[0] = 1'b1;
    repeat (3 * CPB) @(negedge HCLK);
    check_output("glitch_level", 32'(l0), 32'd0);

    $display("[TB] recovery frame 0x3C");
    apply_stimulus(0, 8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge HCLK);
    check_output("recov_level", 32'(l0), 32'd1);
    check_output("recov_data",  32'(d0), 32'h3C);
    check_output("recov_ferr",  32'(f0), 32'd0);

    $display("[TB] overflow on four-entry FIFO");
    for (int i = 1; i <= 5; i++) apply_stimulus(2, 8'(i), 1'b0, 1'b0);
    repeat (40) @(negedge HCLK);
    check_output("ovf_level", 32'(l2), 32'd4);
    check_output("ovf_flag",  32'(o2), 32'd1);
    check_output("ovf_head",  32'(d2), 32'h01);
    for (int i = 1; i <= 4; i++) begin
      check_output("drain_data", 32'(d2), 32'(i));
      pop_entry(2);
    end
    check_output("drain_level", 32'(l2), 32'd0);
    check_output("drain_ovf",   32'(o2), 32'd1);
    clr[2] = 1'b1;
    @(negedge HCLK);
    clr[2] = 1'b0;
    check_output("clr_ovf", 32'(o2), 32'd0);

    $display("[TB] asynchronous reset mid-frame");
    check_output("pre_rst_valid", 32'(v0), 32'd1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    #3;
    HRESETn = 1'b0;
    #1;
    check_output("mid_rst_valid",    32'(v0), 32'd0);
    check_output("mid_rst_level",    32'(l0), 32'd0);
    check_output("mid_rst_data",     32'(d0), 32'd0);
    check_output("mid_rst_ferr",     32'(f0), 32'd0);
    check_output("mid_rst_perr",     32'(p0), 32'd0);
    check_output("mid_rst_overflow", 32'(o0), 32'd0);
    rx_line[0] = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);
    apply_stimulus(0, 8'hA5, 1'b0, 1'b0);
    repeat (40) @(negedge HCLK);
    check_output("post_rst_level", 32'(l0), 32'd1);
    check_output("post_rst_data",  32'(d0), 32'hA5);
    check_output("post_rst_ferr",  32'(f0), 32'd0);
    check_output("post_rst_perr",  32'(p0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
